tictactoe_game_ctrl: RTL
========================

TICTACTOE_GAME_CTRL -- requirements
Module: tictactoe_game_ctrl

Interface
REQ-001 Parameter FIRST_PLAYER, default 1'b0, mover after reset/new game (0: O, 1: X).
REQ-002 Port clk_10000Hz  input  1  sole clock; all state on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port new_game  input  1  level, synchronous restart request.
REQ-005 Port move_valid  input  1  level move request (button, pre-debounced).
REQ-006 Port move_pos  input  4  target cell 0..8, row-major, cell 0 top-left.
REQ-007 Port whosTurn  output  1  current mover (0: O, 1: X); feeds DotMatrix.
REQ-008 Port gameend  output  2  00 not end / 01 O win / 10 X win / 11 draw; feeds DotMatrix.
REQ-009 Port board_o  output  9  bit i set = O occupies cell i.
REQ-010 Port board_x  output  9  bit i set = X occupies cell i.
REQ-011 Port move_ack  output  1  one-cycle pulse, move accepted.
REQ-012 Port move_err  output  1  one-cycle pulse, move rejected.

Function
REQ-013 Move request = rising edge of move_valid (registered previous value low, current high); a held level yields exactly one request.
REQ-014 FSM states PLAY, CHECK, END; all outputs registered.
REQ-015 PLAY + request, move_pos <= 8, cell empty in both boards: set bit in board of whosTurn, move_ack=1 next cycle, go CHECK.
REQ-016 PLAY + request, move_pos > 8 or cell occupied: board unchanged, move_err=1 next cycle, stay PLAY.
REQ-017 CHECK lasts exactly one cycle; evaluates the 8 win lines (3 rows, 3 cols, 2 diagonals) on the mover's registered board.
REQ-018 CHECK, line complete: gameend = 01 (mover O) or 10 (mover X), whosTurn unchanged, go END.
REQ-019 CHECK, no line, board full (board_o|board_x = 9'h1FF): handled per REQ-027/028.
REQ-020 CHECK, otherwise: whosTurn toggles, go PLAY; gameend stays 00.
REQ-021 Request arriving in CHECK or END: ignored for board, move_err=1.
REQ-022 Win on the 9th move takes priority over draw.
REQ-023 new_game high in any state: boards cleared, gameend=00, whosTurn=FIRST_PLAYER, go PLAY next cycle; overrides any same-cycle move request (no ack/err).
REQ-024 Latency: request edge to board update 1 cycle; to gameend/whosTurn update 2 cycles.
REQ-025 move_ack and move_err never high in the same cycle.

Reset
REQ-026 reset low (async): state=PLAY, board_o=board_x=0, gameend=00, whosTurn=FIRST_PLAYER, move_ack=move_err=0, edge-detect register=0; a move_valid already high at reset release produces no request.

Configuration
REQ-027 DRAW_DETECT_EN defined: full board without win in CHECK sets gameend=11, go END.
REQ-028 DRAW_DETECT_EN undefined: full board without win toggles whosTurn, go PLAY, gameend stays 00; every later move rejected (occupied) until new_game/reset; gameend never 11.

Structure
REQ-029 Package tictactoe_pkg holds FSM state encoding, gameend codes (GE_NONE, GE_O_WIN, GE_X_WIN, GE_DRAW), player codes, and the 8 win-line 9-bit masks.
REQ-030 Sub-module win_detect: combinational, 9-bit board in, 1-bit win out, instantiated once on the mover's board.

Verification
REQ-031 Reset, O plays 0, X 3, O 1, X 4, O 2 -> after last move gameend=01 two cycles later, whosTurn=0, board_o=9'h007, board_x=9'h018.
REQ-032 O plays 4, X plays 4 -> second request move_err=1, board_x=0, whosTurn stays 1.
REQ-033 move_pos=4'd12 in PLAY -> move_err=1, boards unchanged; move_valid held high 100 cycles -> exactly one ack/err.
REQ-034 Sequence 0,1,2,4,3,5,7,6,8 (no line) -> DRAW_DETECT_EN: gameend=11; without: gameend=00, next move move_err=1.
REQ-035 After X win (gameend=10), request -> move_err; new_game pulse -> boards 0, gameend=00, whosTurn=FIRST_PLAYER; same-cycle new_game+move -> no ack/err.
REQ-036 Assert reset low mid-CHECK -> all outputs at REQ-026 values immediately, no clock required.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// ---------------------------------------------------------------------------
// tictactoe_pkg
// Shared definitions for the tic-tac-toe game controller:
//   - state_t    : controller FSM states (PLAY, CHECK, END)
//   - GE_*       : gameend output codes
//   - PLAYER_*   : whosTurn encoding
//   - WIN_LINES  : the 8 winning-line masks over the 9-cell board
//   - cell_mask  : one-hot cell mask for a move position (0 if off-board)
// Board bit i is cell i, row-major, cell 0 top-left.
// ---------------------------------------------------------------------------
package tictactoe_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_END   = 2'b10
  } state_t;

  localparam logic [1:0] GE_NONE  = 2'b00;
  localparam logic [1:0] GE_O_WIN = 2'b01;
  localparam logic [1:0] GE_X_WIN = 2'b10;
  localparam logic [1:0] GE_DRAW  = 2'b11;

  localparam logic PLAYER_O = 1'b0;
  localparam logic PLAYER_X = 1'b1;

  // Rows, columns, then the two diagonals.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  // Positions beyond the last cell map to an empty mask so they can never
  // be accepted as a move.
  function automatic logic [8:0] cell_mask(input logic [3:0] pos);
    logic [8:0] mask;
    if (pos <= 4'd8) begin
      mask = 9'd1 << pos;
    end else begin
      mask = 9'd0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/tictactoe_game_ctrl_win_detect.sv
// ---------------------------------------------------------------------------
// win_detect
// Combinational check whether one player's board completes any of the
// 8 winning lines.
// Ports:
//   board : 9-bit occupancy of a single player (bit i = cell i)
//   win   : high when at least one line is fully occupied
// ---------------------------------------------------------------------------
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [8:0] board,
  output logic       win
);

  // OR together the match of every line mask.
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      win = win | ((board & WIN_LINES[i]) == WIN_LINES[i]);
    end
  end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// ---------------------------------------------------------------------------
// tictactoe_game_ctrl
// Two-player tic-tac-toe controller. A rising edge on move_valid is a move
// request for cell move_pos by the current mover. Legal moves are placed,
// then checked one cycle later for a win / full board.
// Ports:
//   clk_10000Hz : sole clock, rising edge
//   reset       : asynchronous active-low reset
//   new_game    : synchronous restart, overrides any move request
//   move_valid  : level move request (edge detected internally)
//   move_pos    : target cell 0..8 (row-major)
//   whosTurn    : current mover (0: O, 1: X)
//   gameend     : 00 running / 01 O win / 10 X win / 11 draw
//   board_o     : cells held by O
//   board_x     : cells held by X
//   move_ack    : one-cycle pulse, move accepted
//   move_err    : one-cycle pulse, move rejected
// Build option: define DRAW_DETECT_EN to report a full board without a
// winner as a draw (gameend=11). Without it, the game simply stays in play
// and every further move is rejected as occupied.
// ---------------------------------------------------------------------------
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
)(
  input  logic       clk_10000Hz,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       whosTurn,
  output logic [1:0] gameend,
  output logic [8:0] board_o,
  output logic [8:0] board_x,
  output logic       move_ack,
  output logic       move_err
);

  state_t     state_r;
  logic       move_valid_prev_r;
  // Cleared by reset and set after the first clock, so a move_valid level
  // already high when reset releases is not seen as a fresh edge.
  logic       armed_r;

  logic       request_s;
  logic [8:0] cell_s;
  logic       legal_s;
  logic [8:0] mover_board_s;
  logic       full_s;
  logic       win_s;

  assign request_s     = armed_r & move_valid & ~move_valid_prev_r;
  assign cell_s        = cell_mask(move_pos);
  assign legal_s       = (cell_s != 9'd0) && ((cell_s & (board_o | board_x)) == 9'd0);
  assign mover_board_s = (whosTurn == PLAYER_X) ? board_x : board_o;
  assign full_s        = &(board_o | board_x);

  win_detect u_win_detect (
    .board (mover_board_s),
    .win   (win_s)
  );

  // Game FSM with edge detection; every output is a register.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      state_r           <= ST_PLAY;
      move_valid_prev_r <= 1'b0;
      armed_r           <= 1'b0;
      board_o           <= 9'd0;
      board_x           <= 9'd0;
      gameend           <= GE_NONE;
      whosTurn          <= FIRST_PLAYER;
      move_ack          <= 1'b0;
      move_err          <= 1'b0;
    end else begin
      move_valid_prev_r <= move_valid;
      armed_r           <= 1'b1;
      move_ack          <= 1'b0;
      move_err          <= 1'b0;
      if (new_game) begin
        state_r  <= ST_PLAY;
        board_o  <= 9'd0;
        board_x  <= 9'd0;
        gameend  <= GE_NONE;
        whosTurn <= FIRST_PLAYER;
      end else begin
        case (state_r)
          ST_PLAY: begin
            if (request_s) begin
              if (legal_s) begin
                if (whosTurn == PLAYER_X) begin
                  board_x <= board_x | cell_s;
                end else begin
                  board_o <= board_o | cell_s;
                end
                move_ack <= 1'b1;
                state_r  <= ST_CHECK;
              end else begin
                move_err <= 1'b1;
              end
            end else begin
              state_r <= ST_PLAY;
            end
          end
          ST_CHECK: begin
            move_err <= request_s;
            // Win is tested first so a winning 9th move is never a draw.
            if (win_s) begin
              gameend <= (whosTurn == PLAYER_X) ? GE_X_WIN : GE_O_WIN;
              state_r <= ST_END;
            end else if (full_s) begin
`ifdef DRAW_DETECT_EN
              gameend <= GE_DRAW;
              state_r <= ST_END;
`else
              whosTurn <= ~whosTurn;
              state_r  <= ST_PLAY;
`endif
            end else begin
              whosTurn <= ~whosTurn;
              state_r  <= ST_PLAY;
            end
          end
          ST_END: begin
            move_err <= request_s;
          end
          default: begin
            state_r <= ST_PLAY;
          end
        endcase
      end
    end
  end

endmodule
